// File: rtl/bsg_fifo_packet_pkg.sv
// Shared types and default widths for the bridge-word <-> fabric-packet adapter.
package bsg_fifo_packet_pkg;

  localparam int fifo_width_gp   = 32;
  localparam int packet_width_gp = 128;

  typedef enum logic {
    E_TX_FILL = 1'b0,
    E_TX_SEND = 1'b1
  } tx_state_e;

  typedef enum logic {
    E_RX_IDLE  = 1'b0,
    E_RX_DRAIN = 1'b1
  } rx_state_e;

  // Never returns 0 so a single-word packet still gets a legal counter width.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_packet_to_words.sv
// Receive path: latches one wide packet and hands it to the bridge one word at a time.
//   state      | meaning
//   E_RX_IDLE  | waiting for a packet, packet_ready_o high
//   E_RX_DRAIN | presenting slot rx_cnt_r on rx_data_o until the last word is taken
module bsg_packet_to_words
  import bsg_fifo_packet_pkg::*;
#(
  parameter int fifo_width_p   = fifo_width_gp,
  parameter int packet_width_p = packet_width_gp
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      packet_v_i,
  input  logic [packet_width_p-1:0] packet_data_i,
  output logic                      packet_ready_o,
  output logic                      rx_v_o,
  output logic [fifo_width_p-1:0]   rx_data_o,
  input  logic                      rx_ready_i,
  output logic [31:0]               rx_packets_o
);

  localparam int words_lp     = packet_width_p / fifo_width_p;
  localparam int cnt_width_lp = safe_clog2(words_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(words_lp - 1);

  rx_state_e                                  state_r, state_n;
  logic [cnt_width_lp-1:0]                    rx_cnt_r, rx_cnt_n;
  logic [words_lp-1:0][fifo_width_p-1:0]      pkt_r;
  logic [31:0]                                packets_r;
  logic                                       accept, word_hs;

  assign packet_ready_o = (state_r == E_RX_IDLE) & reset_n_i;
  assign rx_v_o         = (state_r == E_RX_DRAIN);
  assign accept         = packet_v_i & packet_ready_o;
  assign word_hs        = rx_v_o & rx_ready_i;
  assign rx_packets_o   = packets_r;

  always_comb begin
    rx_data_o = '0;
    for (int i = 0; i < words_lp; i++) begin
      if (rx_cnt_r == cnt_width_lp'(i)) rx_data_o = pkt_r[i];
    end
  end

  always_comb begin
    state_n  = state_r;
    rx_cnt_n = rx_cnt_r;
    case (state_r)
      E_RX_IDLE: begin
        if (accept) begin
          state_n  = E_RX_DRAIN;
          rx_cnt_n = '0;
        end
      end
      E_RX_DRAIN: begin
        if (word_hs) begin
          if (rx_cnt_r == last_cnt_lp) begin
            state_n  = E_RX_IDLE;
            rx_cnt_n = '0;
          end else begin
            rx_cnt_n = rx_cnt_r + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= E_RX_IDLE;
      rx_cnt_r  <= '0;
      pkt_r     <= '0;
      packets_r <= '0;
    end else begin
      state_r  <= state_n;
      rx_cnt_r <= rx_cnt_n;
      if (accept) begin
        pkt_r     <= packet_data_i;
        packets_r <= packets_r + 32'd1;
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_packet_adapter.sv
// Gathers host words into fabric packets (tx) and splits fabric packets into host words (rx).
//   state     | meaning
//   E_TX_FILL | accepting host words into slot tx_cnt_r, LSW first
//   E_TX_SEND | full packet held on packet_data_o until downstream takes it
module bsg_fifo_packet_adapter
  import bsg_fifo_packet_pkg::*;
#(
  parameter int fifo_width_p   = fifo_width_gp,
  parameter int packet_width_p = packet_width_gp
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      tx_v_i,
  input  logic [fifo_width_p-1:0]   tx_data_i,
  output logic                      tx_ready_o,
  output logic                      packet_v_o,
  output logic [packet_width_p-1:0] packet_data_o,
  input  logic                      packet_ready_i,
  input  logic                      packet_v_i,
  input  logic [packet_width_p-1:0] packet_data_i,
  output logic                      packet_ready_o,
  output logic                      rx_v_o,
  output logic [fifo_width_p-1:0]   rx_data_o,
  input  logic                      rx_ready_i,
  output logic [31:0]               tx_packets_o,
  output logic [31:0]               rx_packets_o
);

  localparam int words_lp     = packet_width_p / fifo_width_p;
  localparam int cnt_width_lp = safe_clog2(words_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(words_lp - 1);

  tx_state_e                             tx_state_r, tx_state_n;
  logic [cnt_width_lp-1:0]               tx_cnt_r, tx_cnt_n;
  logic [words_lp-1:0][fifo_width_p-1:0] tx_pkt_r;
  logic [31:0]                           tx_packets_r;
  logic                                  word_hs, pkt_hs;

  // Ready is forced low during reset so the bridge never sees a phantom accept.
  assign tx_ready_o    = (tx_state_r == E_TX_FILL) & reset_n_i;
  assign packet_v_o    = (tx_state_r == E_TX_SEND);
  assign packet_data_o = tx_pkt_r;
  assign tx_packets_o  = tx_packets_r;
  assign word_hs       = tx_v_i & tx_ready_o;
  assign pkt_hs        = packet_v_o & packet_ready_i;

  always_comb begin
    tx_state_n = tx_state_r;
    tx_cnt_n   = tx_cnt_r;
    case (tx_state_r)
      E_TX_FILL: begin
        if (word_hs) begin
          if (tx_cnt_r == last_cnt_lp) begin
            tx_state_n = E_TX_SEND;
            tx_cnt_n   = '0;
          end else begin
            tx_cnt_n = tx_cnt_r + 1'b1;
          end
        end
      end
      E_TX_SEND: begin
        if (pkt_hs) tx_state_n = E_TX_FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state_r   <= E_TX_FILL;
      tx_cnt_r     <= '0;
      tx_pkt_r     <= '0;
      tx_packets_r <= '0;
    end else begin
      tx_state_r <= tx_state_n;
      tx_cnt_r   <= tx_cnt_n;
      for (int i = 0; i < words_lp; i++) begin
        if (word_hs && (tx_cnt_r == cnt_width_lp'(i))) tx_pkt_r[i] <= tx_data_i;
      end
      if (pkt_hs) tx_packets_r <= tx_packets_r + 32'd1;
    end
  end

  bsg_packet_to_words #(
    .fifo_width_p  (fifo_width_p),
    .packet_width_p(packet_width_p)
  ) u_rx (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .packet_v_i    (packet_v_i),
    .packet_data_i (packet_data_i),
    .packet_ready_o(packet_ready_o),
    .rx_v_o        (rx_v_o),
    .rx_data_o     (rx_data_o),
    .rx_ready_i    (rx_ready_i),
    .rx_packets_o  (rx_packets_o)
  );

endmodule

// File: doc/bsg_fifo_packet_adapter.md
# bsg_fifo_packet_adapter

Converts between the 32-bit word streams of the host AXI-Lite FIFO bridge and the wide packets used by the fabric-side endpoint. On transmit it gathers `words_lp` consecutive host words into one packet. On receive it splits each incoming packet into words for the bridge's receive FIFO. It sits directly downstream (tx) and upstream (rx) of one bridge slot; instantiate one per slot.

## Interface
- `fifo_width_p`, 32: word width; must be 32.
- `packet_width_p`, 128: packet width; must be a nonzero multiple of `fifo_width_p`. Derived: `words_lp = packet_width_p/fifo_width_p`, `cnt_width_lp = BSG_SAFE_CLOG2(words_lp)`.
- `clk_i`, in, 1: single clock.
- `reset_n_i`, in, 1: reset, asynchronous, active-low.
- `tx_v_i`, in, 1: host word valid (from bridge `fifo_v_o`).
- `tx_data_i`, in, fifo_width_p: host word.
- `tx_ready_o`, out, 1: word accepted when `tx_v_i & tx_ready_o` (drives bridge `fifo_rdy_i`).
- `packet_v_o`, out, 1: assembled packet valid.
- `packet_data_o`, out, packet_width_p: assembled packet.
- `packet_ready_i`, in, 1: downstream accepts the packet.
- `packet_v_i`, in, 1: incoming packet valid.
- `packet_data_i`, in, packet_width_p: incoming packet.
- `packet_ready_o`, out, 1: incoming packet accepted when `packet_v_i & packet_ready_o`.
- `rx_v_o`, out, 1: word valid (to bridge `fifo_v_i`).
- `rx_data_o`, out, fifo_width_p: word.
- `rx_ready_i`, in, 1: bridge accepts the word (`fifo_rdy_o`).
- `tx_packets_o`, out, 32: count of packets sent, wraps at 2^32.
- `rx_packets_o`, out, 32: count of packets received, wraps at 2^32.

## Operation
Transmit FSM, `E_TX_FILL` → `E_TX_SEND`:
- **E_TX_FILL:** `tx_ready_o=1`, `packet_v_o=0`. Each accepted word is written to slot `tx_cnt_r` of the packet register; slot 0 is bits [31:0] (LSW first). `tx_cnt_r` then increments.
- When the accepted word is slot `words_lp-1`: `tx_cnt_r` returns to 0 and the FSM moves to E_TX_SEND.
- **E_TX_SEND:** `tx_ready_o=0`, `packet_v_o=1`, and `packet_data_o` is held stable. On `packet_ready_i`: return to E_TX_FILL and increment `tx_packets_o`.
- `packet_v_o` must not depend combinationally on `packet_ready_i`.

Receive FSM, `E_RX_IDLE` → `E_RX_DRAIN`:
- **E_RX_IDLE:** `packet_ready_o=1`, `rx_v_o=0`. An accepted packet is latched whole, `rx_cnt_r` is set to 0, and the FSM moves to E_RX_DRAIN. `rx_packets_o` increments on the accept.
- **E_RX_DRAIN:** `packet_ready_o=0`, `rx_v_o=1`, `rx_data_o` = slot `rx_cnt_r` of the latched packet. Each `rx_ready_i` advances `rx_cnt_r`. On the handshake of slot `words_lp-1`, return to E_RX_IDLE.

The two FSMs are fully independent. Simultaneous tx and rx activity has no interaction.

Boundary conditions:
- `words_lp=1`: every accepted word produces a packet; the counters are unused (held at 0).
- A word is never accepted while a packet is pending. Back-pressure propagates to the bridge FIFO.
- A stalled `rx_ready_i` holds `rx_data_o` and `rx_cnt_r` indefinitely.

Reset (`reset_n_i` low, takes effect immediately, including mid-packet):
- FSMs go to FILL/IDLE.
- Counters, packet registers and statistics clear to 0.
- All outputs read 0, including `tx_ready_o` and `packet_ready_o`, which are gated low while reset is asserted.
- Partially gathered or drained packets are discarded.

## Timing
- Tx latency: the word `words_lp-1` handshake in cycle N gives `packet_v_o=1` in cycle N+1.
- Tx throughput: at most 1 packet per `words_lp+1` cycles.
- Rx latency: packet accept in cycle N gives the first word on `rx_v_o` in cycle N+1. The last word handshake in cycle M gives `packet_ready_o=1` in cycle M+1.
- Rx throughput: at most 1 packet per `words_lp+1` cycles.
- All state, data and statistics registers use asynchronous active-low reset. Handshake outputs are decoded from registered state only.

## Structure
- Shared package `bsg_fifo_packet_pkg` holds the `tx_state_e` and `rx_state_e` enums and the default width constants.
- Rx path is sub-module `bsg_packet_to_words`: its FSM, latch and counter. The tx assembler stays in the top module.

## Test plan
All scenarios use `packet_width_p=128` (`words_lp=4`) unless stated.
- **Tx basic:** words 0x11,0x22,0x33,0x44 on back-to-back cycles, `packet_ready_i=1` → `packet_data_o`=0x…44_…33_…22_…11, `packet_v_o` high exactly 1 cycle, one cycle after the 4th word; `tx_packets_o`=1.
- **Tx back-pressure:** hold `packet_ready_i=0` for 10 cycles with the 5th word 0x55 valid → `tx_ready_o=0` and data stable throughout. Release → 0x55 accepted the next cycle as slot 0.
- **Rx drain with stalls:** packet 0x4444_4444_3333_3333_2222_2222_1111_1111 with `rx_ready_i` toggling 1,0,1,0… → words 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order; `packet_ready_o` returns one cycle after the last handshake.
- **Full duplex:** continuous tx and rx streams for 100 packets → both statistics counters equal 100, with no data corruption against a scoreboard.
- **Mid-packet reset:** assert `reset_n_i` low after 2 tx words and 1 rx word → all outputs 0 asynchronously. After release, a fresh 4-word sequence forms a packet with no stale words.
- **Degenerate width:** `packet_width_p=32` → each word passes through with 1-cycle latency, at one transfer per 2 cycles.
